cpu_run_monitor: RTL and testbench
==================================

# cpu_run_monitor

Parametrised run-control and end-of-test monitor that replaces the fixed-duration `$finish` used by the per-program CPU benches. It sits beside `cpu` in every bench, watches the retire stream, and ends a run on a halt opcode, a branch-to-self loop, or a cycle timeout. It reports cycle, retired-instruction and bubble counts plus a termination status. It is synthesizable, so the same block also serves FPGA bring-up.

## Interface
- `PC_W`, 32: width of the retire PC.
- `INSTR_W`, 32: width of the retired instruction word.
- `CNT_W`, 32: width of all counters.
- `MAX_CYCLES`, 2500: timeout limit in RUN cycles. Must be ≥1.
- `HALT_INSTR`, 32'hFFFF_FFFF: instruction encoding treated as halt.
- `LOOP_LIMIT`, 8: consecutive same-PC retirements that count as a halt. Must be ≥2.
- `DRAIN_CYCLES`, 4: cycles waited after a halt so in-flight stores land.
- `clk`, in, 1: clock. Everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: level-sampled run request.
- `retire_valid`, in, 1: an instruction retires this cycle.
- `retire_pc`, in, PC_W: PC of the retiring instruction.
- `retire_instr`, in, INSTR_W: retiring instruction word.
- `running`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: high in DONE.
- `status`, out, 2: termination code.
- `cycle_count`, out, CNT_W: cycles spent in RUN.
- `instr_count`, out, CNT_W: valid retirements seen in RUN.
- `bubble_count`, out, CNT_W: RUN cycles with `retire_valid`=0.

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → DRAIN on halt.
  - RUN → DONE on timeout.
  - DRAIN → DONE when the drain counter reaches DRAIN_CYCLES.
  - DONE → RUN on `start`.
- `status` codes:
  - NONE=0, while IDLE, RUN or DRAIN.
  - HALT_OP=1.
  - HALT_LOOP=2.
  - TIMEOUT=3.
- Entering RUN clears all three counters and the loop detector.
- Counters in RUN:
  - `cycle_count` increments every RUN cycle.
  - `instr_count` increments on `retire_valid`.
  - `bubble_count` increments when `retire_valid` is low.
  - All three saturate at all-ones and are frozen outside RUN.
- Halt-opcode detection: `retire_valid` and `retire_instr`==HALT_INSTR.
- Loop detection:
  - A run counter tracks consecutive valid retirements whose `retire_pc` equals the last valid PC.
  - Bubbles neither reset nor advance it. A different PC resets it to 1.
  - A halt fires when it reaches LOOP_LIMIT.
- Timeout fires in the RUN cycle in which the updated `cycle_count` equals MAX_CYCLES.
- Simultaneous events:
  - Halt opcode and loop in the same cycle: HALT_OP.
  - Halt and timeout in the same cycle: the halt wins.
- `start` while in RUN or DRAIN is ignored.
- Reset at any point, including mid-run: IDLE with every counter, `status` and the detector cleared.

## Timing
- Reset values: `running`=0, `done`=0, `status`=0, all counters 0.
- `start` high in cycle t: `running`=1 at t+1, and t+1 is the first counted RUN cycle.
- Halt retirement in cycle h:
  - The retirement is counted in `instr_count`.
  - DRAIN begins at h+1.
  - `done`=1 and `status` valid at h+1+DRAIN_CYCLES.
  - With DRAIN_CYCLES=0, `done`=1 at h+1.
- Timeout: `done`=1 the cycle after `cycle_count` reaches MAX_CYCLES, and `cycle_count` reads exactly MAX_CYCLES.
- `status` and the counters hold in DONE until the next `start` or `reset`.

## Configuration
- `CPU_RUN_MONITOR_FINISH_EN` defined: on entering DONE, the block `$display`s the status, the three counters and CPI (cycles/instructions, or "n/a" if zero), then calls `$finish`. This is simulation only.
- Not defined: no system tasks. The bench or FPGA logic reads the outputs.

## Structure
- `cpu_run_monitor_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the status enum (NONE, HALT_OP, HALT_LOOP, TIMEOUT);
  - the default HALT_INSTR constant.
- One sub-module, `cpu_run_loop_detect`:
  - Ports: `clk`, `reset`, `clear`, `retire_valid`, `retire_pc`.
  - Output: `loop_hit`.
  - Parameters: `PC_W` and `LOOP_LIMIT`.

## Test plan
- `start` at cycle 2, 10 retirements of distinct PCs, then HALT_INSTR at cycle 14, DRAIN_CYCLES=4 → `done` at 19, `status`=1, `instr_count`=11, `cycle_count`=12.
- PC 0x40 retired 8 times interleaved with bubbles → `status`=2; bubbles counted, detector not reset by them.
- No halt, MAX_CYCLES=50 → `done` after the 50th RUN cycle, `status`=3, `cycle_count`=50.
- HALT_INSTR retired exactly on the MAX_CYCLES cycle → `status`=1 and DRAIN entered.
- `reset` asserted mid-DRAIN → next cycle IDLE, all outputs 0. A following `start` gives a fresh run with counters from 0.
- Alternating `retire_valid` (one-stall pattern) over 20 RUN cycles → `instr_count`=10, `bubble_count`=10.

Source files
------------

// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run monitor and its loop detector.
package cpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        HALT_OP   = 2'd1,
        HALT_LOOP = 2'd2,
        TIMEOUT   = 2'd3
    } status_e;

    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_run_loop_detect.sv
// Branch-to-self detector: counts consecutive valid retirements of the same PC.
module cpu_run_loop_detect
    import cpu_run_monitor_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int LOOP_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            retire_valid,
    input  logic [PC_W-1:0] retire_pc,
    output logic            loop_hit
);

    localparam int RUN_W = $clog2(LOOP_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(LOOP_LIMIT);

    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic             have_pc_q, have_pc_d;
    logic [RUN_W-1:0] run_q, run_d;

    // Bubbles leave the run untouched; the count saturates at the limit.
    always_comb begin
        last_pc_d = last_pc_q;
        have_pc_d = have_pc_q;
        run_d     = run_q;
        if (retire_valid) begin
            last_pc_d = retire_pc;
            have_pc_d = 1'b1;
            if (have_pc_q && (retire_pc == last_pc_q)) begin
                if (run_q != RUN_LIMIT) begin
                    run_d = run_q + RUN_ONE;
                end
            end else begin
                run_d = RUN_ONE;
            end
        end
        loop_hit = retire_valid && (run_d == RUN_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            last_pc_q <= '0;
            have_pc_q <= 1'b0;
            run_q     <= '0;
        end else begin
            last_pc_q <= last_pc_d;
            have_pc_q <= have_pc_d;
            run_q     <= run_d;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and end-of-test monitor watching the CPU retire stream.
// Define CPU_RUN_MONITOR_FINISH_EN to print a run summary and $finish on entering DONE.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int                 PC_W         = 32,
    parameter int                 INSTR_W      = 32,
    parameter int                 CNT_W        = 32,
    parameter int                 MAX_CYCLES   = 2500,
    parameter logic [INSTR_W-1:0] HALT_INSTR   = INSTR_W'(DEFAULT_HALT_INSTR),
    parameter int                 LOOP_LIMIT   = 8,
    parameter int                 DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               retire_valid,
    input  logic [PC_W-1:0]    retire_pc,
    input  logic [INSTR_W-1:0] retire_instr,
    output logic               running,
    output logic               done,
    output logic [1:0]         status,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES);
    localparam logic [31:0]      DRAIN_END = 32'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    status_e          status_q, status_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [31:0]      drain_q, drain_d;
    logic [CNT_W-1:0] cycle_inc, instr_inc, bubble_inc;
    logic             loop_clear;
    logic             loop_hit;
    logic             halt_op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_ONE;
    endfunction

    cpu_run_loop_detect #(
        .PC_W       (PC_W),
        .LOOP_LIMIT (LOOP_LIMIT)
    ) u_loop_detect (
        .clk          (clk),
        .reset        (reset),
        .clear        (loop_clear),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .loop_hit     (loop_hit)
    );

    assign cycle_inc  = sat_inc(cycle_q);
    assign instr_inc  = sat_inc(instr_q);
    assign bubble_inc = sat_inc(bubble_q);
    assign halt_op    = retire_valid && (retire_instr == HALT_INSTR);

    // A halt beats a timeout in the same cycle, and an opcode halt beats a loop halt.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        cycle_d    = cycle_q;
        instr_d    = instr_q;
        bubble_d   = bubble_q;
        drain_d    = drain_q;
        loop_clear = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    status_d   = NONE;
                    cycle_d    = '0;
                    instr_d    = '0;
                    bubble_d   = '0;
                    drain_d    = '0;
                    loop_clear = 1'b1;
                end
            end
            RUN: begin
                cycle_d = cycle_inc;
                if (retire_valid) begin
                    instr_d = instr_inc;
                end else begin
                    bubble_d = bubble_inc;
                end
                if (halt_op || loop_hit) begin
                    status_d = halt_op ? HALT_OP : HALT_LOOP;
                    drain_d  = '0;
                    state_d  = (DRAIN_END == 32'd0) ? DONE : DRAIN;
                end else if (cycle_inc == CNT_LIMIT) begin
                    status_d = TIMEOUT;
                    state_d  = DONE;
                end
            end
            DRAIN: begin
                if ((drain_q + 32'd1) == DRAIN_END) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= NONE;
            cycle_q  <= '0;
            instr_q  <= '0;
            bubble_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
            bubble_q <= bubble_d;
            drain_q  <= drain_d;
        end
    end

    // Status is only published once the run has fully ended.
    assign running      = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign status       = (state_q == DONE) ? status_q : NONE;
    assign cycle_count  = cycle_q;
    assign instr_count  = instr_q;
    assign bubble_count = bubble_q;

`ifdef CPU_RUN_MONITOR_FINISH_EN
    state_e report_state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            report_state_q <= IDLE;
        end else begin
            report_state_q <= state_q;
            if ((state_q == DONE) && (report_state_q != DONE)) begin
                $display("cpu_run_monitor: status=%0d cycles=%0d instrs=%0d bubbles=%0d",
                         status_q, cycle_q, instr_q, bubble_q);
                if (instr_q == '0) begin
                    $display("cpu_run_monitor: CPI n/a");
                end else begin
                    $display("cpu_run_monitor: CPI %0.3f", real'(cycle_q) / real'(instr_q));
                end
                $finish;
            end
        end
    end
`else
    // Without the report hook the outputs are read by the surrounding bench or FPGA logic.
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: vector table plus hand-written corner sequences.
module tb_cpu_run_monitor;

    localparam int          PC_W     = 32;
    localparam int          INSTR_W  = 32;
    localparam int          CNT_W    = 32;
    localparam int          MAX_CYC  = 50;
    localparam int          LOOP_LIM = 8;
    localparam int          DRAIN    = 4;
    localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               retire_valid;
    logic [PC_W-1:0]    retire_pc;
    logic [INSTR_W-1:0] retire_instr;
    logic               running;
    logic               done;
    logic [1:0]         status;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   instr_count;
    logic [CNT_W-1:0]   bubble_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        eRun;
        logic        eDone;
        logic [1:0]  eStat;
        int          eCyc;
        int          eIns;
        int          eBub;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .PC_W         (PC_W),
        .INSTR_W      (INSTR_W),
        .CNT_W        (CNT_W),
        .MAX_CYCLES   (MAX_CYC),
        .HALT_INSTR   (HALT),
        .LOOP_LIMIT   (LOOP_LIM),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr),
        .running      (running),
        .done         (done),
        .status       (status),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count),
        .bubble_count (bubble_count)
    );

    task automatic addVec(input logic st, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr, input logic eRun, input logic eDone,
                          input logic [1:0] eStat, input int eCyc, input int eIns, input int eBub);
        vec_t x;
        x.st = st; x.v = v; x.pc = pc; x.instr = instr;
        x.eRun = eRun; x.eDone = eDone; x.eStat = eStat;
        x.eCyc = eCyc; x.eIns = eIns; x.eBub = eBub;
        vecs.push_back(x);
    endtask

    // Drive one cycle of inputs, let the edge happen, and settle 1ns past it.
    task automatic applyStimulus(input logic st, input logic v, input logic [31:0] pc,
                                 input logic [31:0] instr);
        start        = st;
        retire_valid = v;
        retire_pc    = pc;
        retire_instr = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eRun, input logic eDone,
                               input logic [1:0] eStat, input int eCyc, input int eIns,
                               input int eBub);
        checks++;
        if (running !== eRun || done !== eDone || status !== eStat ||
            cycle_count !== 32'(eCyc) || instr_count !== 32'(eIns) ||
            bubble_count !== 32'(eBub)) begin
            errors++;
            $display("[TB] FAIL %s: got run=%0d done=%0d status=%0d cyc=%0d ins=%0d bub=%0d, expected run=%0d done=%0d status=%0d cyc=%0d ins=%0d bub=%0d",
                     name, running, done, status, cycle_count, instr_count, bubble_count,
                     eRun, eDone, eStat, eCyc, eIns, eBub);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int ins;
        int b;

        reset        = 1'b1;
        start        = 1'b0;
        retire_valid = 1'b0;
        retire_pc    = '0;
        retire_instr = NOP;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_state", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Scenario A: ten distinct retirements, a bubble, then a halt opcode.
        addVec(1, 0, 32'h0, NOP, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            addVec(i == 1, 1, 32'h100 + 32'(4 * i), NOP, 1, 0, 0, i, i, 0);
        end
        addVec(0, 0, 32'h0, NOP, 1, 0, 0, 11, 10, 1);
        addVec(0, 1, 32'h200, HALT, 1, 0, 0, 12, 11, 1);
        addVec(0, 1, 32'h204, NOP, 1, 0, 0, 12, 11, 1);
        addVec(1, 0, 32'h0, NOP, 1, 0, 0, 12, 11, 1);
        addVec(0, 0, 32'h0, NOP, 1, 0, 0, 12, 11, 1);
        addVec(0, 0, 32'h0, NOP, 0, 1, 1, 12, 11, 1);
        addVec(0, 0, 32'h0, NOP, 0, 1, 1, 12, 11, 1);

        // Scenario B: a different PC resets the run, then PC 0x40 eight times with bubbles.
        addVec(1, 0, 32'h0, NOP, 1, 0, 0, 0, 0, 0);
        c = 0; ins = 0; b = 0;
        for (int i = 0; i < 4; i++) begin
            c++; ins++;
            addVec(0, 1, (i == 3) ? 32'h44 : 32'h40, NOP, 1, 0, 0, c, ins, b);
        end
        for (int k = 0; k < 15; k++) begin
            c++;
            if (k % 2 == 0) begin
                ins++;
                addVec(0, 1, 32'h40, NOP, 1, 0, 0, c, ins, b);
            end else begin
                b++;
                addVec(0, 0, 32'h40, NOP, 1, 0, 0, c, ins, b);
            end
        end
        for (int k = 0; k < 3; k++) begin
            addVec(0, 0, 32'h0, NOP, 1, 0, 0, c, ins, b);
        end
        addVec(0, 0, 32'h0, NOP, 0, 1, 2, c, ins, b);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].v, vecs[i].pc, vecs[i].instr);
            checkOutput($sformatf("vec%0d", i), vecs[i].eRun, vecs[i].eDone, vecs[i].eStat,
                        vecs[i].eCyc, vecs[i].eIns, vecs[i].eBub);
        end

        // Scenario C: pure bubbles until the timeout.
        applyStimulus(1, 0, 32'h0, NOP);
        checkOutput("timeout_start", 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 49; i++) applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("timeout_cycle49", 1, 0, 0, 49, 0, 49);
        applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("timeout_done", 0, 1, 3, 50, 0, 50);
        applyStimulus(0, 1, 32'h10, NOP);
        checkOutput("timeout_hold", 0, 1, 3, 50, 0, 50);

        // Scenario D: halt opcode exactly on the timeout cycle.
        applyStimulus(1, 0, 32'h0, NOP);
        for (int i = 1; i <= 49; i++) applyStimulus(0, 0, 32'h0, NOP);
        applyStimulus(0, 1, 32'h300, HALT);
        checkOutput("halt_on_timeout_drain", 1, 0, 0, 50, 1, 49);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("halt_on_timeout_drain_end", 1, 0, 0, 50, 1, 49);
        applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("halt_on_timeout_done", 0, 1, 1, 50, 1, 49);

        // Scenario G: halt opcode on the same cycle the loop limit is hit.
        applyStimulus(1, 0, 32'h0, NOP);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 32'h80, NOP);
        checkOutput("loop_seven_running", 1, 0, 0, 7, 7, 0);
        applyStimulus(0, 1, 32'h80, HALT);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("halt_and_loop_done", 0, 1, 1, 8, 8, 0);

        // Scenario E: reset in the middle of DRAIN, then a fresh alternating run.
        applyStimulus(1, 0, 32'h0, NOP);
        applyStimulus(0, 1, 32'h500, NOP);
        applyStimulus(0, 1, 32'h504, NOP);
        applyStimulus(0, 1, 32'h508, HALT);
        applyStimulus(0, 0, 32'h0, NOP);
        applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("mid_drain", 1, 0, 0, 3, 3, 0);
        reset = 1'b1;
        applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("reset_mid_drain", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 32'h0, NOP);
        checkOutput("idle_after_reset", 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h0, NOP);
        checkOutput("fresh_start", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, (i % 2) == 0, 32'h600 + 32'(4 * i), NOP);
            if (i == 9) checkOutput("alternate_half", 1, 0, 0, 10, 5, 5);
        end
        checkOutput("alternate_full", 1, 0, 0, 20, 10, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
